// File: rtl/spi_fb_loader_if.sv
// Frame-buffer write port and frame-swap handshake between the SPI loader and the HUB75 core.
interface spi_fb_loader_if #(
    parameter int unsigned N_BANKS = 2,
    parameter int unsigned N_ROWS  = 32,
    parameter int unsigned N_COLS  = 64
);
    localparam int unsigned RA_W       = $clog2(N_BANKS) + $clog2(N_ROWS);
    localparam int unsigned LOG_N_COLS = $clog2(N_COLS);

    logic [RA_W-1:0]       fbw_row_addr;
    logic [LOG_N_COLS-1:0] fbw_col_addr;
    logic [23:0]           fbw_data;
    logic                  fbw_wren;
    logic                  fbw_row_store;
    logic                  fbw_row_swap;
    logic                  fbw_row_rdy;
    logic                  frame_swap;
    logic                  frame_rdy;

    modport master (
        output fbw_row_addr, fbw_col_addr, fbw_data, fbw_wren,
        output fbw_row_store, fbw_row_swap, frame_swap,
        input  fbw_row_rdy, frame_rdy
    );

    modport slave (
        input  fbw_row_addr, fbw_col_addr, fbw_data, fbw_wren,
        input  fbw_row_store, fbw_row_swap, frame_swap,
        output fbw_row_rdy, frame_rdy
    );
endinterface

// File: rtl/spi_fb_loader.sv
// SPI mode-0 slave that decodes host commands, assembles RGB pixels and drives the
// HUB75 frame-buffer row-write port plus the row-store / frame-swap handshakes.
module spi_fb_loader #(
    parameter int unsigned N_BANKS = 2,
    parameter int unsigned N_ROWS  = 32,
    parameter int unsigned N_COLS  = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    spi_fb_loader_if.master fbw
);
    localparam int unsigned LOG_N_BANKS = $clog2(N_BANKS);
    localparam int unsigned LOG_N_ROWS  = $clog2(N_ROWS);
    localparam int unsigned LOG_N_COLS  = $clog2(N_COLS);
    localparam int unsigned RA_W        = LOG_N_BANKS + LOG_N_ROWS;
    localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ROW_ADDR, S_PIX_R, S_PIX_G, S_PIX_B, S_STATUS, S_SINK
    } state_t;

    logic [2:0] sclk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;
    logic       sclk_rise, sclk_fall, cs_n_s, mosi_s;

    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] rx_byte;
    logic       byte_vld;

    state_t                state_q, state_d;
    logic [LOG_N_COLS-1:0] col_q;
    logic [7:0]            red_q, grn_q;
    logic [7:0]            tx_sh;
    logic                  store_pend, swap_pend, ovr;

    logic do_wren, do_row_load, do_red, do_grn, do_store_set, do_swap_set, do_ovr_set, do_status;

    // Pin synchronizers; the third spi_clk flop gives edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q   <= {cs_q[0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_n_s    = cs_q[1];
    assign mosi_s    = mosi_q[1];

    // Byte assembly; a partial byte is dropped when chip select goes high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            rx_sh    <= 7'd0;
            rx_byte  <= 8'd0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            if (cs_n_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                rx_sh   <= {rx_sh[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte  <= {rx_sh, mosi_s};
                    byte_vld <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Command parser: next state and per-byte actions
    always_comb begin
        state_d      = state_q;
        do_wren      = 1'b0;
        do_row_load  = 1'b0;
        do_red       = 1'b0;
        do_grn       = 1'b0;
        do_store_set = 1'b0;
        do_swap_set  = 1'b0;
        do_ovr_set   = 1'b0;
        do_status    = 1'b0;
        if (cs_n_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_CMD;
                S_CMD: if (byte_vld) begin
                    case (rx_byte)
                        8'h10: begin
                            if (store_pend) begin
                                do_ovr_set = 1'b1;
                                state_d    = S_SINK;
                            end else begin
                                state_d = S_ROW_ADDR;
                            end
                        end
                        8'h20: begin
                            do_swap_set = 1'b1;
                            state_d     = S_SINK;
                        end
                        8'h00: begin
                            do_status = 1'b1;
                            state_d   = S_STATUS;
                        end
                        default: state_d = S_SINK;
                    endcase
                end
                S_ROW_ADDR: if (byte_vld) begin
                    do_row_load = 1'b1;
                    state_d     = S_PIX_R;
                end
                S_PIX_R: if (byte_vld) begin
                    do_red  = 1'b1;
                    state_d = S_PIX_G;
                end
                S_PIX_G: if (byte_vld) begin
                    do_grn  = 1'b1;
                    state_d = S_PIX_B;
                end
                S_PIX_B: if (byte_vld) begin
                    do_wren = 1'b1;
                    if (col_q == LAST_COL) begin
                        do_store_set = 1'b1;
                        state_d      = S_SINK;
                    end else begin
                        state_d = S_PIX_R;
                    end
                end
                S_STATUS: state_d = S_STATUS;
                S_SINK:   state_d = S_SINK;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Pixel datapath and row-write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q            <= '0;
            red_q            <= 8'd0;
            grn_q            <= 8'd0;
            fbw.fbw_wren     <= 1'b0;
            fbw.fbw_data     <= 24'd0;
            fbw.fbw_col_addr <= '0;
            fbw.fbw_row_addr <= '0;
        end else begin
            fbw.fbw_wren <= do_wren;
            if (do_red) red_q <= rx_byte;
            if (do_grn) grn_q <= rx_byte;
            if (do_row_load) fbw.fbw_row_addr <= RA_W'(rx_byte);
            if (do_wren) begin
                fbw.fbw_data     <= {red_q, grn_q, rx_byte};
                fbw.fbw_col_addr <= col_q;
            end
            if (cs_n_s || do_row_load) col_q <= '0;
            else if (do_wren)          col_q <= (col_q == LAST_COL) ? '0 : col_q + LOG_N_COLS'(1);
        end
    end

    // Pending store/swap requests; a swap never overtakes an outstanding row store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_pend        <= 1'b0;
            swap_pend         <= 1'b0;
            ovr               <= 1'b0;
            fbw.fbw_row_store <= 1'b0;
            fbw.fbw_row_swap  <= 1'b0;
            fbw.frame_swap    <= 1'b0;
        end else begin
            fbw.fbw_row_store <= 1'b0;
            fbw.fbw_row_swap  <= 1'b0;
            fbw.frame_swap    <= 1'b0;
            if (store_pend && fbw.fbw_row_rdy) begin
                fbw.fbw_row_store <= 1'b1;
                fbw.fbw_row_swap  <= 1'b1;
                store_pend        <= 1'b0;
            end else if (do_store_set) begin
                store_pend <= 1'b1;
            end
            if (swap_pend && fbw.frame_rdy && !store_pend) begin
                fbw.frame_swap <= 1'b1;
                swap_pend      <= 1'b0;
            end else if (do_swap_set) begin
                swap_pend <= 1'b1;
            end
            if (do_status)       ovr <= 1'b0;
            else if (do_ovr_set) ovr <= 1'b1;
        end
    end

    // Status shifter; drains to zero so MISO idles low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh    <= 8'd0;
            spi_miso <= 1'b0;
        end else if (cs_n_s) begin
            tx_sh    <= 8'd0;
            spi_miso <= 1'b0;
        end else if (do_status) begin
            tx_sh <= {store_pend, ovr, swap_pend, 5'b0};
        end else if (sclk_fall) begin
            spi_miso <= tx_sh[7];
            tx_sh    <= {tx_sh[6:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_spi_fb_loader.sv
// Directed bench for spi_fb_loader: bit-banged SPI host, write-port monitor and status readback.
module tb_spi_fb_loader;
    logic clk = 1'b0;
    logic rst_n, spi_clk, spi_cs_n, spi_mosi, spi_miso;

    spi_fb_loader_if #(.N_BANKS(2), .N_ROWS(32), .N_COLS(64)) bus ();

    spi_fb_loader #(.N_BANKS(2), .N_ROWS(32), .N_COLS(64)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .fbw(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Write-port monitor
    int   cyc = 0, wr_cnt = 0, store_cnt = 0, swap_cnt = 0, pair_bad = 0;
    int   wren_cyc = 0, store_cyc = 0, swap_cyc = 0, store_row = 0;
    int   wr_row [1024];
    int   wr_col [1024];
    int   wr_data[1024];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.fbw_wren) begin
                if (wr_cnt < 1024) begin
                    wr_row[wr_cnt]  = int'(bus.fbw_row_addr);
                    wr_col[wr_cnt]  = int'(bus.fbw_col_addr);
                    wr_data[wr_cnt] = int'(bus.fbw_data);
                end
                wr_cnt++;
                wren_cyc = cyc;
            end
            if (bus.fbw_row_store) begin
                store_cnt++;
                store_cyc = cyc;
                store_row = int'(bus.fbw_row_addr);
            end
            if (bus.fbw_row_store != bus.fbw_row_swap) pair_bad++;
            if (bus.frame_swap) begin
                swap_cnt++;
                swap_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    // SPI host, edges aligned to clk negedges, spi_clk = clk/6
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] r;
        r = 8'd0;
        for (int b = 7; b >= 0; b--) begin
            spi_mosi = tx[b];
            #30 spi_clk = 1'b1;
            r = {r[6:0], spi_miso};
            #30 spi_clk = 1'b0;
        end
        rx = r;
    endtask

    task automatic cs_lo();
        @(negedge clk);
        spi_cs_n = 1'b0;
        #30;
    endtask

    task automatic cs_hi();
        #60 spi_cs_n = 1'b1;
        #60;
    endtask

    task automatic send_cmd(input logic [7:0] cmd);
        logic [7:0] d;
        cs_lo();
        xfer(cmd, d);
        cs_hi();
    endtask

    task automatic send_pixels(input logic [7:0] row, input int npix);
        logic [7:0] d;
        xfer(8'h10, d);
        xfer(row, d);
        for (int c = 0; c < npix; c++) begin
            xfer(8'(c), d);
            xfer(8'(c + 1), d);
            xfer(8'(c + 2), d);
        end
    endtask

    task automatic send_row(input logic [7:0] row, input int npix);
        cs_lo();
        send_pixels(row, npix);
        cs_hi();
    endtask

    task automatic get_status(output logic [7:0] st);
        logic [7:0] d;
        cs_lo();
        xfer(8'h00, d);
        xfer(8'h00, st);
        cs_hi();
    endtask

    // Checks the 64 writes of one full row starting at monitor index base
    task automatic chk_row(input int base, input int row);
        for (int c = 0; c < 64; c++) begin
            chk("wr_col", wr_col[base + c], c);
            chk("wr_data", wr_data[base + c], (c << 16) | ((c + 1) << 8) | (c + 2));
            chk("wr_row", wr_row[base + c], row);
        end
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       row_rdy;
        logic       frame_rdy;
        int         exp_wren;
        int         exp_store;
        int         exp_swap;
        logic [7:0] exp_status;
    } vec_t;

    vec_t       tbl[7];
    logic [7:0] st;
    int         w0, s0, f0;

    initial begin
        tbl[0] = '{8'h10, 1'b1, 1'b0, 64, 1, 0, 8'h00};
        tbl[1] = '{8'h20, 1'b1, 1'b0,  0, 0, 0, 8'h20};
        tbl[2] = '{8'h20, 1'b1, 1'b1,  0, 0, 2, 8'h00};
        tbl[3] = '{8'h7F, 1'b1, 1'b1,  0, 0, 0, 8'h00};
        tbl[4] = '{8'h10, 1'b0, 1'b1, 64, 0, 0, 8'h80};
        tbl[5] = '{8'h20, 1'b0, 1'b1,  0, 0, 0, 8'hA0};
        tbl[6] = '{8'h55, 1'b1, 1'b1,  0, 1, 1, 8'h00};

        rst_n = 1'b0;
        spi_clk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        bus.fbw_row_rdy = 1'b0;
        bus.frame_rdy = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_miso", int'(spi_miso), 0);
        chk("rst_wren", int'(bus.fbw_wren), 0);
        chk("rst_store", int'(bus.fbw_row_store), 0);
        chk("rst_rswap", int'(bus.fbw_row_swap), 0);
        chk("rst_fswap", int'(bus.frame_swap), 0);
        chk("rst_data", int'(bus.fbw_data), 0);
        chk("rst_addr", int'({bus.fbw_row_addr, bus.fbw_col_addr}), 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_strobes", wr_cnt + store_cnt + swap_cnt, 0);
        chk("idle_miso", int'(spi_miso), 0);

        // Full row, core ready
        bus.fbw_row_rdy = 1'b1;
        send_row(8'h25, 64);
        repeat (10) @(negedge clk);
        chk("row1_wren_cnt", wr_cnt, 64);
        chk_row(0, 8'h25);
        chk("row1_store_cnt", store_cnt, 1);
        chk("row1_store_row", store_row, 8'h25);
        chk("row1_store_after_wren", int'(store_cyc > wren_cyc), 1);

        // Row store held off by fbw_row_rdy, plus overrun
        bus.fbw_row_rdy = 1'b0;
        w0 = wr_cnt;
        s0 = store_cnt;
        send_row(8'h0A, 64);
        repeat (50) @(negedge clk);
        chk("wait_wren_cnt", wr_cnt - w0, 64);
        chk_row(w0, 8'h0A);
        chk("wait_no_store", store_cnt - s0, 0);
        get_status(st);
        chk("wait_status", int'(st), 8'h80);
        w0 = wr_cnt;
        cs_lo();
        send_pixels(8'h11, 2);
        cs_hi();
        repeat (10) @(negedge clk);
        chk("ovr_no_wren", wr_cnt - w0, 0);
        get_status(st);
        chk("ovr_status", int'(st), 8'hC0);
        get_status(st);
        chk("ovr_cleared", int'(st), 8'h80);
        bus.fbw_row_rdy = 1'b1;
        repeat (50) @(negedge clk);
        chk("rdy_one_store", store_cnt - s0, 1);
        chk("rdy_store_row", store_row, 8'h0A);
        chk("pair_ok", pair_bad, 0);

        // Row abandoned by CS after 10 pixels and one extra byte
        w0 = wr_cnt;
        s0 = store_cnt;
        cs_lo();
        send_pixels(8'h03, 10);
        xfer(8'hAA, st);
        cs_hi();
        repeat (20) @(negedge clk);
        chk("abandon_wren_cnt", wr_cnt - w0, 10);
        chk("abandon_no_store", store_cnt - s0, 0);
        w0 = wr_cnt;
        send_row(8'h03, 64);
        repeat (10) @(negedge clk);
        chk("after_abandon_cnt", wr_cnt - w0, 64);
        chk_row(w0, 8'h03);
        chk("after_abandon_store", store_cnt - s0, 1);

        // Frame swap gated by frame_rdy, then ordered behind a row store
        f0 = swap_cnt;
        bus.frame_rdy = 1'b0;
        send_cmd(8'h20);
        repeat (20) @(negedge clk);
        chk("swap_wait", swap_cnt - f0, 0);
        bus.frame_rdy = 1'b1;
        repeat (40) @(negedge clk);
        chk("swap_one", swap_cnt - f0, 1);
        f0 = swap_cnt;
        s0 = store_cnt;
        bus.fbw_row_rdy = 1'b0;
        send_row(8'h07, 64);
        send_cmd(8'h20);
        repeat (30) @(negedge clk);
        chk("swap_blocked", swap_cnt - f0, 0);
        chk("store_blocked", store_cnt - s0, 0);
        bus.fbw_row_rdy = 1'b1;
        repeat (30) @(negedge clk);
        chk("order_store", store_cnt - s0, 1);
        chk("order_swap", swap_cnt - f0, 1);
        chk("order_swap_after_store", int'(swap_cyc > store_cyc), 1);

        // Command table
        for (int i = 0; i < 7; i++) begin
            w0 = wr_cnt;
            s0 = store_cnt;
            f0 = swap_cnt;
            bus.fbw_row_rdy = tbl[i].row_rdy;
            bus.frame_rdy = tbl[i].frame_rdy;
            repeat (5) @(negedge clk);
            if (tbl[i].cmd == 8'h10) send_row(8'h12, 64);
            else send_cmd(tbl[i].cmd);
            repeat (20) @(negedge clk);
            chk($sformatf("tbl%0d_wren", i), wr_cnt - w0, tbl[i].exp_wren);
            chk($sformatf("tbl%0d_store", i), store_cnt - s0, tbl[i].exp_store);
            chk($sformatf("tbl%0d_swap", i), swap_cnt - f0, tbl[i].exp_swap);
            get_status(st);
            chk($sformatf("tbl%0d_status", i), int'(st), int'(tbl[i].exp_status));
        end

        chk("final_pair_ok", pair_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_fb_loader.md
# spi_fb_loader

SPI slave (responder) that lets an external host push frames into the HUB75 frame buffer over SPI. It replaces the flash-reader/video-generator pair on the framebuffer write side: it decodes host commands, assembles 24-bit RGB pixels, and drives the `fbw_*` row-write port and the frame-swap handshake of the HUB75 core. It runs entirely in the system clock domain and oversamples the SPI pins.

## Interface
- `N_BANKS`, default 2: panel banks.
- `N_ROWS`, default 32: rows per bank.
- `N_COLS`, default 64: pixels per row.
- Derived: `LOG_N_BANKS = $clog2(N_BANKS)`, `LOG_N_ROWS = $clog2(N_ROWS)`, `LOG_N_COLS = $clog2(N_COLS)`, `RA_W = LOG_N_BANKS + LOG_N_ROWS`. Pixel format fixed: 3 channels × 8 planes.

- `clk` in 1: system clock; must be at least 4× `spi_clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_clk` in 1: SPI clock from host, mode 0.
- `spi_cs_n` in 1: chip select from host, active low.
- `spi_mosi` in 1: host data, MSB first.
- `spi_miso` out 1: status data to host; driven 0 when not shifting status (no tristate).
- `fbw_row_addr` out RA_W: `{bank, row}` of the row being loaded.
- `fbw_col_addr` out LOG_N_COLS: pixel column for `fbw_wren`.
- `fbw_data` out 24: pixel `{R[7:0], G[7:0], B[7:0]}`.
- `fbw_wren` out 1: one-cycle pixel write strobe.
- `fbw_row_store` out 1: one-cycle strobe to commit the line buffer to the frame buffer.
- `fbw_row_swap` out 1: asserted together with `fbw_row_store`.
- `fbw_row_rdy` in 1: core can accept a row store.
- `frame_swap` out 1: one-cycle strobe to swap displayed frame.
- `frame_rdy` in 1: core can accept a frame swap.

## Operation
- Front end: `spi_clk`, `spi_cs_n`, `spi_mosi` each pass through a 2-flop synchronizer; rising/falling edges of synchronized `spi_clk` are detected from a third flop.
- Sample `spi_mosi` on `spi_clk` rising edge; shift `spi_miso` on falling edge. 3-bit bit counter; byte completes on the 8th rising edge, producing an internal `byte_vld` pulse.
- `spi_cs_n` high: bit counter, byte parser and column counter return to idle; partial byte discarded; a row whose pixels are incomplete is abandoned (no store). Pending store/swap requests already latched are kept.
- Parser FSM states: IDLE → CMD → (ROW_ADDR → PIX_R → PIX_G → PIX_B, loop) | STATUS | SINK.
- Commands (first byte after CS falls):
  - `0x10` WRITE_ROW: next byte is row address (low RA_W bits used, rest ignored), then N_COLS × 3 bytes R,G,B. Each completed B byte issues `fbw_wren` with current column, then column increments. After column N_COLS-1: set `store_pend`, go to SINK.
  - `0x20` SWAP: set `swap_pend`, go to SINK.
  - `0x00` STATUS: load status byte `{busy, ovr, frame_pend, 5'b0}` (busy = `store_pend`, frame_pend = `swap_pend`) into MISO shifter; MSB driven from the next falling edge; clears `ovr` after load.
  - Other: SINK.
- SINK ignores all bytes until CS high.
- `store_pend` set: `fbw_row_store` and `fbw_row_swap` pulse high for one cycle in the first cycle `fbw_row_rdy` is high; `store_pend` clears.
- `swap_pend`: `frame_swap` pulses in the first cycle `frame_rdy` is high and `store_pend` is low (swap never overtakes a row store).
- Overrun: WRITE_ROW command received while `store_pend` is set → set sticky `ovr`, go to SINK, no `fbw_wren` issued. SWAP while `swap_pend` set → no effect.

## Timing
- Reset: every output 0 (`spi_miso`, `fbw_*`, `frame_swap`); FSM IDLE; `store_pend`, `swap_pend`, `ovr`, counters 0.
- `byte_vld` occurs 3 `clk` after the 8th `spi_clk` rising pin edge; `fbw_wren` registered 1 cycle after that B `byte_vld`. `fbw_data`/`fbw_col_addr`/`fbw_row_addr` stable during `fbw_wren`.
- `fbw_row_store` earliest 1 cycle after last `fbw_wren`.
- Store/swap strobes are single-cycle regardless of how long `*_rdy` stays high.
- `fbw_row_addr` held from ROW_ADDR byte until the store strobe completes.

## Test plan
- Reset with all SPI pins idle → all outputs 0; no strobes for 100 cycles.
- WRITE_ROW `0x10`, row `0x25`, 64 pixels `R=c,G=c+1,B=c+2` → 64 `fbw_wren` with col 0..63, data `{c,c+1,c+2}`, row addr `0x25`, then one store+swap pulse with `fbw_row_rdy=1`.
- Same with `fbw_row_rdy=0` for 50 cycles → no store until `rdy` rises, then exactly one pulse; STATUS during wait returns `0x80`.
- WRITE_ROW while store pending → no `fbw_wren`; STATUS returns `0xC0`, next STATUS `0x80`.
- CS raised after 10 pixels + 1 byte → 10 writes, no store; next full row works normally from col 0.
- SWAP with `frame_rdy=0`, then `frame_rdy=1` → one `frame_swap` pulse; SWAP issued with a store pending → `frame_swap` only after the store pulse.
